syrup_mem2p_responder: RTL

SYRUP_MEM2P_RESPONDER -- requirements
Module: syrup_mem2p_responder

---
 rtl/syrup_pkg.sv | 17 +
 rtl/syrup_mem2p_responder_if.sv | 23 ++
 rtl/syrup_sp_ram.sv | 45 ++++
 rtl/syrup_mem2p_responder.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/syrup_pkg.sv
// Shared definitions for the syrup two-port memory responder.
// Holds the FSM state encoding and the byte-lane address helper.
package syrup_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DEFER = 1'b1
    } state_e;

    localparam int unsigned ByteW = 8;

    // Number of low address bits that select a byte within one data word.
    function automatic int unsigned lane_off_bits(input int unsigned data_width);
        return $clog2(data_width / ByteW);
    endfunction

endpackage

// File: rtl/syrup_mem2p_responder_if.sv
// Two-port memory request/response bundle shared by requester and responder.
// The master modport is the requester side, the slave modport is the memory side.
interface syrup_mem2p_responder_if #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   ADDR0, ADDR1;
    logic [DATA_WIDTH-1:0]   D0, D1;
    logic                    WE0, WE1, RE0, RE1;
    logic [DATA_WIDTH/8-1:0] BE0, BE1;
    logic [DATA_WIDTH-1:0]   Q0, Q1;
    logic                    STALL;

    modport master (
        output ADDR0, ADDR1, D0, D1, WE0, WE1, RE0, RE1, BE0, BE1,
        input  Q0, Q1, STALL
    );

    modport slave (
        input  ADDR0, ADDR1, D0, D1, WE0, WE1, RE0, RE1, BE0, BE1,
        output Q0, Q1, STALL
    );
endinterface

// File: rtl/syrup_sp_ram.sv
// Single-port storage array, read-before-write, one-cycle registered read.
// Byte-lane write masking is enabled by the SYRUP_BYTE_ENABLE_EN macro.
module syrup_sp_ram
    import syrup_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG  = 10
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [DEPTH_LOG-1:0]    addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int unsigned Lanes = DATA_WIDTH / ByteW;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem[addr_i];
            if (we_i) begin
`ifdef SYRUP_BYTE_ENABLE_EN
                for (int i = 0; i < Lanes; i++) begin
                    if (be_i[i]) begin
                        mem[addr_i][i*ByteW +: ByteW] <= wdata_i[i*ByteW +: ByteW];
                    end
                end
`else
                mem[addr_i] <= wdata_i;
`endif
            end
        end
    end

`ifndef SYRUP_BYTE_ENABLE_EN
    logic unused_be;
    assign unused_be = ^be_i;
`endif

    assign rdata_o = rdata_q;
endmodule

// File: rtl/syrup_mem2p_responder.sv
// Two-port memory responder arbitrating both ports onto one single-port array.
// Optional byte-lane writes under SYRUP_BYTE_ENABLE_EN.
module syrup_mem2p_responder
    import syrup_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG  = 10
) (
    input logic                    CLK,
    input logic                    RST,
    syrup_mem2p_responder_if.slave bus
);
    localparam int unsigned B   = lane_off_bits(DATA_WIDTH);
    localparam int unsigned BeW = DATA_WIDTH / 8;

    logic [DEPTH_LOG-1:0] a0, a1;
    logic                 stall, req0, req1;

    state_e               state_q, state_d;
    logic [DEPTH_LOG-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                 hold_we_q, hold_we_d, hold_re_q, hold_re_d;
    logic [BeW-1:0]       hold_be_q, hold_be_d;
    logic                 rd_valid_q, rd_valid_d, rd_port_q, rd_port_d;
    logic [DATA_WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;

    logic                 ram_en, ram_we;
    logic [DEPTH_LOG-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
    logic [BeW-1:0]       ram_be;

    // Address bits above the storage depth alias onto lower words.
    assign a0 = bus.ADDR0[DEPTH_LOG+B-1:B];
    assign a1 = bus.ADDR1[DEPTH_LOG+B-1:B];

    logic unused_addr;
    assign unused_addr = ^{bus.ADDR0, bus.ADDR1};

    assign stall = (state_q == DEFER);
    assign req0  = (bus.WE0 | bus.RE0) & ~stall;
    assign req1  = (bus.WE1 | bus.RE1) & ~stall;

    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_we_d   = hold_we_q;
        hold_re_d   = hold_re_q;
        hold_be_d   = hold_be_q;
        rd_valid_d  = 1'b0;
        rd_port_d   = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = a0;
        ram_wdata   = bus.D0;
        ram_be      = bus.BE0;
        unique case (state_q)
            IDLE: begin
                if (req0) begin
                    ram_en     = 1'b1;
                    ram_we     = bus.WE0;
                    rd_valid_d = bus.RE0;
                    if (req1) begin
                        hold_addr_d = a1;
                        hold_data_d = bus.D1;
                        hold_we_d   = bus.WE1;
                        hold_re_d   = bus.RE1;
                        hold_be_d   = bus.BE1;
                        state_d     = DEFER;
                    end
                end else if (req1) begin
                    ram_en     = 1'b1;
                    ram_we     = bus.WE1;
                    ram_addr   = a1;
                    ram_wdata  = bus.D1;
                    ram_be     = bus.BE1;
                    rd_valid_d = bus.RE1;
                    rd_port_d  = 1'b1;
                end
            end
            DEFER: begin
                ram_en     = hold_we_q | hold_re_q;
                ram_we     = hold_we_q;
                ram_addr   = hold_addr_q;
                ram_wdata  = hold_data_q;
                ram_be     = hold_be_q;
                rd_valid_d = hold_re_q;
                rd_port_d  = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data appears straight from the array the cycle after the read, then is held.
    always_comb begin
        q0_d = q0_q;
        q1_d = q1_q;
        if (rd_valid_q) begin
            if (rd_port_q) q1_d = ram_rdata;
            else           q0_d = ram_rdata;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_we_q   <= 1'b0;
            hold_re_q   <= 1'b0;
            hold_be_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_port_q   <= 1'b0;
            q0_q        <= '0;
            q1_q        <= '0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_we_q   <= hold_we_d;
            hold_re_q   <= hold_re_d;
            hold_be_q   <= hold_be_d;
            rd_valid_q  <= rd_valid_d;
            rd_port_q   <= rd_port_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
        end
    end

    assign bus.Q0    = q0_d;
    assign bus.Q1    = q1_d;
    assign bus.STALL = stall;

    syrup_sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG  (DEPTH_LOG)
    ) u_ram (
        .clk_i   (CLK),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .be_i    (ram_be),
        .rdata_o (ram_rdata)
    );
endmodule
